// File: rtl/shift_subtract_divider_pkg.sv
// Shared types and helpers for the shift/subtract divider slice.
package divider_pkg;

  localparam int DIVIDER_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WORKING = 2'd1,
    DONE    = 2'd2
  } divider_state_t;

  function automatic int divider_count_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/shift_subtract_divider_if.sv
// Start/ready handshake plus operand and result bus of the divider.
interface shift_subtract_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  ready, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output ready, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/shift_subtract_divider_controller.sv
// Controller FSM for the restoring divider (IDLE -> WORKING -> DONE).
// DIVIDER_FAST_DIV_ZERO_EN adds a direct IDLE -> DONE path for a zero divisor.
module divider_controller
  import divider_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic counter_is_zero,
`ifdef DIVIDER_FAST_DIV_ZERO_EN
  input  logic divisor_is_zero,
`endif
  output logic ready,
  output logic datapath_do_init,
  output logic datapath_do_step,
  output logic counter_do_preset,
  output logic counter_do_decrement
);

  localparam logic [1:0] ST_IDLE    = 2'(IDLE);
  localparam logic [1:0] ST_WORKING = 2'(WORKING);
  localparam logic [1:0] ST_DONE    = 2'(DONE);

  logic [1:0] state_q, state_d;

  always_comb begin
    state_d              = state_q;
    datapath_do_init     = 1'b0;
    datapath_do_step     = 1'b0;
    counter_do_preset    = 1'b0;
    counter_do_decrement = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          datapath_do_init = 1'b1;
`ifdef DIVIDER_FAST_DIV_ZERO_EN
          if (divisor_is_zero) begin
            state_d = ST_DONE;
          end else begin
            counter_do_preset = 1'b1;
            state_d           = ST_WORKING;
          end
`else
          counter_do_preset = 1'b1;
          state_d           = ST_WORKING;
`endif
        end
      end
      ST_WORKING: begin
        datapath_do_step = 1'b1;
        if (counter_is_zero) state_d = ST_DONE;
        else                 counter_do_decrement = 1'b1;
      end
      ST_DONE: begin
        if (!start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Decoded from state only so a client never sees start loop back to ready.
  assign ready = (state_q == ST_DONE);

endmodule

// File: rtl/shift_subtract_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, A/Q/M datapath.
// Optional DIVIDER_FAST_DIV_ZERO_EN: finish a zero-divisor request in one edge.
module shift_subtract_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIVIDER_DEFAULT_WIDTH
) (
  input  logic                      clock,
  input  logic                      reset,
  shift_subtract_divider_if.slave   bus
);

  localparam int CW = divider_count_width(WIDTH);

  logic [WIDTH:0]   a_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] m_q;
  logic [CW-1:0]    cnt_q;
  logic             dbz_q;

  logic datapath_do_init, datapath_do_step;
  logic counter_do_preset, counter_do_decrement;

  divider_controller u_ctrl (
    .clock                (clock),
    .reset                (reset),
    .start                (bus.start),
    .counter_is_zero      (cnt_q == '0),
`ifdef DIVIDER_FAST_DIV_ZERO_EN
    .divisor_is_zero      (bus.divisor == '0),
`endif
    .ready                (bus.ready),
    .datapath_do_init     (datapath_do_init),
    .datapath_do_step     (datapath_do_step),
    .counter_do_preset    (counter_do_preset),
    .counter_do_decrement (counter_do_decrement)
  );

  // One restoring step: A' = {A,Q} << 1 (upper part), trial T = A' - M.
  logic [WIDTH:0] a_sh;
  logic [WIDTH:0] t;
  assign a_sh = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign t    = a_sh - {1'b0, m_q};

  always_ff @(posedge clock) begin
    if (reset) begin
      a_q   <= '0;
      q_q   <= '0;
      m_q   <= '0;
      cnt_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      if (datapath_do_init) begin
        a_q   <= '0;
        q_q   <= bus.dividend;
        m_q   <= bus.divisor;
        dbz_q <= (bus.divisor == '0);
`ifdef DIVIDER_FAST_DIV_ZERO_EN
        if (bus.divisor == '0) begin
          a_q <= {1'b0, bus.dividend};
          q_q <= '1;
        end
`endif
      end else if (datapath_do_step) begin
        a_q <= t[WIDTH] ? a_sh : t;
        q_q <= {q_q[WIDTH-2:0], ~t[WIDTH]};
      end

      if (counter_do_preset)         cnt_q <= CW'(WIDTH - 1);
      else if (counter_do_decrement) cnt_q <= cnt_q - CW'(1);
    end
  end

  // The partial remainder always fits in WIDTH bits between steps; the extra
  // bit only matters inside the trial subtraction.
  always_comb begin
    assert (reset || !a_q[WIDTH]);
  end

  assign bus.quotient    = q_q;
  assign bus.remainder   = a_q[WIDTH-1:0];
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_shift_subtract_divider.sv
// Directed + scoreboarded bench for shift_subtract_divider (WIDTH=8 and WIDTH=16 instances).
module tb_shift_subtract_divider;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  shift_subtract_divider_if #(.WIDTH(8))  b8 ();
  shift_subtract_divider_if #(.WIDTH(16)) b16 ();

  shift_subtract_divider #(.WIDTH(8))  dut8  (.clock(clock), .reset(reset), .bus(b8));
  shift_subtract_divider #(.WIDTH(16)) dut16 (.clock(clock), .reset(reset), .bus(b16));

`ifdef DIVIDER_FAST_DIV_ZERO_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  function automatic int exp_lat(input int width, input bit zero);
    return (FAST && zero) ? 1 : width + 1;
  endfunction

  // Raise start with operands and count edges (including the sampling edge) until ready.
  task automatic go8(input logic [7:0] dd, input logic [7:0] ds, output int lat);
    @(negedge clock);
    b8.dividend = dd; b8.divisor = ds; b8.start = 1'b1;
    lat = 0;
    do begin @(posedge clock); #1; lat++; end while (!b8.ready && lat < 40);
  endtask

  task automatic drop8();
    @(negedge clock); b8.start = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (b8.ready !== 1'b0)       begin errors++; $display("FAIL reset_ready got %0d want 0", b8.ready); end
    checks++; if (b8.quotient !== 8'd0)    begin errors++; $display("FAIL reset_quot got %0d want 0", b8.quotient); end
    checks++; if (b8.remainder !== 8'd0)   begin errors++; $display("FAIL reset_rem got %0d want 0", b8.remainder); end
    checks++; if (b8.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %0d want 0", b8.div_by_zero); end
    @(negedge clock); reset = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    go8(8'd13, 8'd4, lat);
    checks++; if (lat != 9)                 begin errors++; $display("FAIL basic_lat got %0d want 9", lat); end
    checks++; if (b8.quotient !== 8'd3)     begin errors++; $display("FAIL basic_quot got %0d want 3", b8.quotient); end
    checks++; if (b8.remainder !== 8'd1)    begin errors++; $display("FAIL basic_rem got %0d want 1", b8.remainder); end
    checks++; if (b8.div_by_zero !== 1'b0)  begin errors++; $display("FAIL basic_dbz got %0d want 0", b8.div_by_zero); end
    drop8();
    checks++; if (b8.ready !== 1'b0)        begin errors++; $display("FAIL basic_idle_ready got %0d want 0", b8.ready); end
  endtask

  task automatic test_back_to_back();
    int lat;
    go8(8'd255, 8'd1, lat);
    checks++; if (lat != 9)                 begin errors++; $display("FAIL b2b1_lat got %0d want 9", lat); end
    checks++; if (b8.quotient !== 8'd255)   begin errors++; $display("FAIL b2b1_quot got %0d want 255", b8.quotient); end
    checks++; if (b8.remainder !== 8'd0)    begin errors++; $display("FAIL b2b1_rem got %0d want 0", b8.remainder); end
    drop8();
    repeat (2) @(posedge clock);
    #1;
    checks++; if (b8.quotient !== 8'd255)   begin errors++; $display("FAIL b2b1_hold_quot got %0d want 255", b8.quotient); end
    go8(8'd7, 8'd9, lat);
    checks++; if (lat != 9)                 begin errors++; $display("FAIL b2b2_lat got %0d want 9", lat); end
    checks++; if (b8.quotient !== 8'd0)     begin errors++; $display("FAIL b2b2_quot got %0d want 0", b8.quotient); end
    checks++; if (b8.remainder !== 8'd7)    begin errors++; $display("FAIL b2b2_rem got %0d want 7", b8.remainder); end
    drop8();
    repeat (2) @(posedge clock);
    #1;
    checks++; if (b8.remainder !== 8'd7)    begin errors++; $display("FAIL b2b2_hold_rem got %0d want 7", b8.remainder); end
  endtask

  task automatic test_div_zero();
    int lat;
    go8(8'd200, 8'd0, lat);
    checks++; if (lat != exp_lat(8, 1'b1))  begin errors++; $display("FAIL dz_lat got %0d want %0d", lat, exp_lat(8, 1'b1)); end
    checks++; if (b8.quotient !== 8'd255)   begin errors++; $display("FAIL dz_quot got %0d want 255", b8.quotient); end
    checks++; if (b8.remainder !== 8'd200)  begin errors++; $display("FAIL dz_rem got %0d want 200", b8.remainder); end
    checks++; if (b8.div_by_zero !== 1'b1)  begin errors++; $display("FAIL dz_flag got %0d want 1", b8.div_by_zero); end
    drop8();
    checks++; if (b8.div_by_zero !== 1'b1)  begin errors++; $display("FAIL dz_hold_flag got %0d want 1", b8.div_by_zero); end
  endtask

  task automatic test_churn();
    int lat;
    @(negedge clock);
    b8.dividend = 8'd100; b8.divisor = 8'd7; b8.start = 1'b1;
    lat = 0;
    do begin
      @(posedge clock); #1; lat++;
      if (!b8.ready) begin b8.dividend = 8'($urandom); b8.divisor = 8'($urandom); end
    end while (!b8.ready && lat < 40);
    checks++; if (lat != 9)                 begin errors++; $display("FAIL churn_lat got %0d want 9", lat); end
    checks++; if (b8.quotient !== 8'd14)    begin errors++; $display("FAIL churn_quot got %0d want 14", b8.quotient); end
    checks++; if (b8.remainder !== 8'd2)    begin errors++; $display("FAIL churn_rem got %0d want 2", b8.remainder); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); b8.dividend = 8'($urandom); b8.divisor = 8'($urandom);
      @(posedge clock); #1;
      checks++; if (b8.ready !== 1'b1)      begin errors++; $display("FAIL churn_hold_ready got %0d want 1", b8.ready); end
      checks++; if (b8.quotient !== 8'd14)  begin errors++; $display("FAIL churn_hold_quot got %0d want 14", b8.quotient); end
    end
    drop8();
    checks++; if (b8.ready !== 1'b0)        begin errors++; $display("FAIL churn_idle_ready got %0d want 0", b8.ready); end
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clock);
    b8.dividend = 8'd50; b8.divisor = 8'd3; b8.start = 1'b1;
    @(posedge clock);          // sampled: first WORKING cycle follows
    repeat (3) @(posedge clock); // now in the 4th WORKING cycle
    @(negedge clock); reset = 1'b1; b8.start = 1'b0;
    @(posedge clock); #1;
    checks++; if (b8.ready !== 1'b0)        begin errors++; $display("FAIL rmid_ready got %0d want 0", b8.ready); end
    checks++; if (b8.quotient !== 8'd0)     begin errors++; $display("FAIL rmid_quot got %0d want 0", b8.quotient); end
    checks++; if (b8.remainder !== 8'd0)    begin errors++; $display("FAIL rmid_rem got %0d want 0", b8.remainder); end
    checks++; if (b8.div_by_zero !== 1'b0)  begin errors++; $display("FAIL rmid_dbz got %0d want 0", b8.div_by_zero); end
    @(negedge clock); reset = 1'b0;
    go8(8'd50, 8'd3, lat);
    checks++; if (lat != 9)                 begin errors++; $display("FAIL rmid_lat got %0d want 9", lat); end
    checks++; if (b8.quotient !== 8'd16)    begin errors++; $display("FAIL rmid_quot2 got %0d want 16", b8.quotient); end
    checks++; if (b8.remainder !== 8'd2)    begin errors++; $display("FAIL rmid_rem2 got %0d want 2", b8.remainder); end
    drop8();
  endtask

  task automatic test_random16();
    logic [15:0] corner_dd [8] = '{16'd0, 16'd1, 16'hFFFF, 16'hFFFF, 16'd5, 16'hFFFF, 16'd0, 16'h1234};
    logic [15:0] corner_ds [8] = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd7, 16'hFFFF, 16'd5, 16'd1};
    logic [15:0] dd, ds, eq, er;
    logic [31:0] recon;
    int lat;
    for (int n = 0; n < 1000; n++) begin
      if (n < 8) begin dd = corner_dd[n]; ds = corner_ds[n]; end
      else begin
        dd = 16'($urandom);
        case ($urandom_range(0, 5))
          0: ds = 16'd0;
          1: ds = 16'd1;
          2: ds = dd + 16'($urandom_range(1, 100)); // usually dividend < divisor
          3: ds = 16'($urandom_range(1, 255));
          default: ds = 16'($urandom);
        endcase
      end
      eq = (ds == 0) ? 16'hFFFF : dd / ds;
      er = (ds == 0) ? dd : dd % ds;
      @(negedge clock);
      b16.dividend = dd; b16.divisor = ds; b16.start = 1'b1;
      lat = 0;
      do begin @(posedge clock); #1; lat++; end while (!b16.ready && lat < 60);
      checks++; if (lat != exp_lat(16, ds == 0)) begin errors++; $display("FAIL r16_lat %0d/%0d got %0d want %0d", dd, ds, lat, exp_lat(16, ds == 0)); end
      checks++; if (b16.quotient !== eq)  begin errors++; $display("FAIL r16_quot %0d/%0d got %0d want %0d", dd, ds, b16.quotient, eq); end
      checks++; if (b16.remainder !== er) begin errors++; $display("FAIL r16_rem %0d/%0d got %0d want %0d", dd, ds, b16.remainder, er); end
      checks++; if (b16.div_by_zero !== (ds == 0)) begin errors++; $display("FAIL r16_dbz %0d/%0d got %0d want %0d", dd, ds, b16.div_by_zero, ds == 0); end
      if (ds != 0) begin
        recon = 32'(b16.quotient) * 32'(ds) + 32'(b16.remainder);
        checks++;
        if (recon != 32'(dd) || b16.remainder >= ds) begin
          errors++; $display("FAIL r16_identity %0d/%0d got q=%0d r=%0d want q*d+r=%0d with r<d", dd, ds, b16.quotient, b16.remainder, dd);
        end
      end
      @(negedge clock); b16.start = 1'b0;
      @(posedge clock); #1;
    end
  endtask

  initial begin
    b8.start = 1'b0;  b8.dividend = '0;  b8.divisor = '0;
    b16.start = 1'b0; b16.dividend = '0; b16.divisor = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_churn();
    test_reset_mid();
    test_random16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
